tone_detector: RTL and testbench
================================

Name: tone_detector

Overview:
- Receive-side counterpart of the note buzzer. Measures the period of an incoming square-wave tone and decodes it back to the same seven one-hot note lines (LA, DO, MI, SOL, RE, FA, SI).
- Used for loopback self-test of the buzzer path and for decoding externally played tones in the FSM game logic.
- Runs at 50 MHz. Note periods are full-cycle clock counts.

Parameters:
- PER_W, 20, width of the period counter; the counter saturates at 2^PER_W-1.
- TOL_SHIFT, 6, acceptance window per note is nominal ± (nominal >> TOL_SHIFT), about ±1.56%.
- CONFIRM, 2, number of consecutive same-class periods required before the outputs change (range 1..7).
- TIMEOUT, 262143, number of clocks without a rising edge before the input is declared silent.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- tone_in  in  1  asynchronous square-wave input
- LA, DO, MI, SOL, RE, FA, SI  out  1 each  one-hot decoded note, all 0 when no note is locked
- silent  out  1  high when no rising edge has been seen within TIMEOUT clocks
- note_strobe  out  1  one-cycle pulse when the outputs change to a new non-zero note

Behaviour:
- Reset (async, immediate):
  - All note outputs 0, silent=1, note_strobe=0.
  - State=SILENT; synchronizer flops, per_cnt, cand and match_cnt all cleared.
- Input path:
  - tone_in passes through a 2-flop synchronizer, then an edge register.
  - rise = sync & ~prev.
  - Latency from pin edge to rise is 2-3 clocks.
- per_cnt:
  - Loaded with 1 on rise; otherwise increments, saturating.
  - On rise, the measured period equals the per_cnt value before the load, i.e. clocks between consecutive rises.
- Classification (combinational, on the measured period): code 1..7 = LA, DO, MI, SOL, RE, FA, SI. Nominal periods:
  - LA 113636
  - DO 47778
  - MI 37922
  - SOL 127551
  - RE 42566
  - FA 35793
  - SI 50619
- Window rules:
  - Windows are inclusive at both ends.
  - Out of all windows → code 0 (unknown).
  - Window overlap is impossible at the defaults; if it occurs, the priority order is LA > DO > MI > SOL > RE > FA > SI.
- States:
  - SILENT: on rise → ARMED. No period is evaluated, and match_cnt stays 0.
  - ARMED / LOCKED, on each rise:
    - If code == cand, match_cnt increments (saturating at CONFIRM).
    - Otherwise cand = code and match_cnt = 1.
  - When match_cnt reaches CONFIRM, the outputs update on the next clock edge:
    - cand ≠ 0 and cand differs from the current note → note outputs = onehot(cand), silent=0, note_strobe=1 for one cycle, state=LOCKED.
    - cand ≠ 0 and cand equals the current note → no change and no strobe.
    - cand = 0 → all notes 0, silent=0, state=ARMED, no strobe.
- Hold rule: outputs never change on a single deviating period. The old note is held until the new class is confirmed. Between notes, the outputs switch in one cycle and are never both high.
- Timeout:
  - In ARMED or LOCKED, when per_cnt == TIMEOUT with no rise that cycle → state=SILENT, notes 0, silent=1, cand and match_cnt cleared.
  - Fires once per silence episode.
  - A constant high or constant low input both time out.
- Simultaneous rise and per_cnt == TIMEOUT: the rise wins. The period (TIMEOUT) classifies as 0, and there is no timeout that cycle.
- silent deasserts only when a confirmed classification occurs, not on the first edge.

Decomposition:
- Package tone_pkg contains:
  - note code constants 0..7
  - NOTE_W=3
  - nominal period constants, shared with the buzzer
  - the classification function
- Sub-module tone_period_meter contains the synchronizer, edge detect and saturating per_cnt. It outputs rise and the measured period.
- tone_detector contains the classification, confirmation FSM, timeout and output registers.

Test Plan:
- Reset asserted mid-stream → all notes 0 and silent=1 asynchronously. After release, the outputs do not change until first rise + CONFIRM periods.
- 50% square wave, period 113636 clocks → after the 3rd rise, LA=1 and silent=0, with note_strobe high for exactly 1 cycle within 4 clocks of the 3rd synced rise.
- Locked LA, then switch to period 35793 → LA held through the 1st FA period; after the 2nd FA period, FA=1 and LA=0 in the same cycle, with one strobe.
- Locked MI, then 2 periods of 37000 (between the FA and MI windows) → all notes 0, silent=0, no strobe. A single 37000 period alone leaves MI held.
- Boundary on DO: periods of 48524 are accepted (DO=1); periods of 48525 give code 0 (notes cleared after CONFIRM).
- Locked SOL, then tone_in held high → exactly 262143 clocks after the last rise: silent=1 and notes 0. Repeat with tone_in held low for the same result.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone path (buzzer and detector).
//   - note codes 1..7 (LA, DO, MI, SOL, RE, FA, SI), 0 = unknown
//   - nominal full-cycle periods in 50 MHz clocks
//   - classify(): period -> note code, inclusive windows nominal +/- (nominal >> tol_shift)
//   - note_onehot(): note code -> {SI,FA,RE,SOL,MI,DO,LA}
package tone_pkg;

  localparam int unsigned NOTE_W = 3;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_NONE = 3'd0,
    NOTE_LA   = 3'd1,
    NOTE_DO   = 3'd2,
    NOTE_MI   = 3'd3,
    NOTE_SOL  = 3'd4,
    NOTE_RE   = 3'd5,
    NOTE_FA   = 3'd6,
    NOTE_SI   = 3'd7
  } note_t;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } det_state_t;

  localparam logic [31:0] PER_LA  = 32'd113636;
  localparam logic [31:0] PER_DO  = 32'd47778;
  localparam logic [31:0] PER_MI  = 32'd37922;
  localparam logic [31:0] PER_SOL = 32'd127551;
  localparam logic [31:0] PER_RE  = 32'd42566;
  localparam logic [31:0] PER_FA  = 32'd35793;
  localparam logic [31:0] PER_SI  = 32'd50619;

  function automatic logic in_window(input logic [31:0] period,
                                     input logic [31:0] nominal,
                                     input int unsigned tol_shift);
    logic [31:0] tol;
    tol = nominal >> tol_shift;
    return (period >= (nominal - tol)) && (period <= (nominal + tol));
  endfunction

  // Checked in priority order so an overlap (only possible with a wide
  // tolerance) resolves deterministically.
  function automatic note_t classify(input logic [31:0] period,
                                     input int unsigned tol_shift);
    note_t code;
    code = NOTE_NONE;
    if      (in_window(period, PER_LA,  tol_shift)) code = NOTE_LA;
    else if (in_window(period, PER_DO,  tol_shift)) code = NOTE_DO;
    else if (in_window(period, PER_MI,  tol_shift)) code = NOTE_MI;
    else if (in_window(period, PER_SOL, tol_shift)) code = NOTE_SOL;
    else if (in_window(period, PER_RE,  tol_shift)) code = NOTE_RE;
    else if (in_window(period, PER_FA,  tol_shift)) code = NOTE_FA;
    else if (in_window(period, PER_SI,  tol_shift)) code = NOTE_SI;
    return code;
  endfunction

  function automatic logic [6:0] note_onehot(input note_t code);
    logic [6:0] oh;
    oh = '0;
    case (code)
      NOTE_LA:  oh = 7'b000_0001;
      NOTE_DO:  oh = 7'b000_0010;
      NOTE_MI:  oh = 7'b000_0100;
      NOTE_SOL: oh = 7'b000_1000;
      NOTE_RE:  oh = 7'b001_0000;
      NOTE_FA:  oh = 7'b010_0000;
      NOTE_SI:  oh = 7'b100_0000;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// tone_period_meter: synchronises tone_in, detects rising edges and counts
// clocks between them.
//   clk, rst  : system clock, async active-high reset
//   tone_in   : asynchronous square-wave input
//   rise      : one-cycle pulse on a synchronised rising edge
//   period    : running clock count since the last rise (saturating); sampled
//               while rise is high it is the full period just completed
module tone_period_meter #(
  parameter int unsigned PER_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             rise,
  output logic [PER_W-1:0] period
);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [PER_W-1:0] per_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // Loaded with 1 on a rise so that the value seen at the next rise is the
  // exact number of clocks between the two rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (rise) begin
      per_cnt <= PER_W'(1);
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  assign period = per_cnt;

endmodule

// File: rtl/tone_detector.sv
// tone_detector: decodes an incoming square-wave tone to seven one-hot note
// lines by period measurement, with multi-period confirmation and silence
// timeout.
//   clk, rst        : 50 MHz clock, async active-high reset
//   tone_in         : asynchronous square-wave input
//   LA..SI          : one-hot decoded note, all 0 when nothing is locked
//   silent          : no rising edge within TIMEOUT clocks
//   note_strobe     : one-cycle pulse when outputs change to a new note
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned PER_W     = 20,
  parameter int unsigned TOL_SHIFT = 6,
  parameter int unsigned CONFIRM   = 2,
  parameter int unsigned TIMEOUT   = 262143
) (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic LA,
  output logic DO,
  output logic MI,
  output logic SOL,
  output logic RE,
  output logic FA,
  output logic SI,
  output logic silent,
  output logic note_strobe
);

  localparam logic [2:0]       CONFIRM_C = 3'(CONFIRM);
  localparam logic [PER_W-1:0] TIMEOUT_C = PER_W'(TIMEOUT);

  logic             rise;
  logic [PER_W-1:0] period;
  note_t            code;
  logic             timeout_hit;

  det_state_t state, state_nxt;
  note_t      cand, cand_nxt;
  logic [2:0] match_cnt, match_nxt;
  logic [6:0] notes, notes_nxt;
  logic       silent_nxt;
  logic       strobe_nxt;

  tone_period_meter #(
    .PER_W(PER_W)
  ) u_meter (
    .clk    (clk),
    .rst    (rst),
    .tone_in(tone_in),
    .rise   (rise),
    .period (period)
  );

  assign code = classify(32'(period), TOL_SHIFT);

  // per_cnt keeps counting past TIMEOUT, so this matches only once per
  // silence episode; a coincident rise takes precedence.
  assign timeout_hit = (period == TIMEOUT_C) && !rise;

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    match_nxt  = match_cnt;
    notes_nxt  = notes;
    silent_nxt = silent;
    strobe_nxt = 1'b0;

    if (timeout_hit && (state != ST_SILENT)) begin
      state_nxt  = ST_SILENT;
      cand_nxt   = NOTE_NONE;
      match_nxt  = '0;
      notes_nxt  = '0;
      silent_nxt = 1'b1;
    end else begin
      // Output update acts on the registered confirmation, one clock after
      // the rise that completed it; re-evaluating while saturated is a no-op.
      if ((state != ST_SILENT) && (match_cnt == CONFIRM_C)) begin
        if (cand == NOTE_NONE) begin
          notes_nxt  = '0;
          silent_nxt = 1'b0;
          state_nxt  = ST_ARMED;
        end else if (note_onehot(cand) != notes) begin
          notes_nxt  = note_onehot(cand);
          silent_nxt = 1'b0;
          strobe_nxt = 1'b1;
          state_nxt  = ST_LOCKED;
        end
      end

      if (rise) begin
        if (state == ST_SILENT) begin
          state_nxt = ST_ARMED;
        end else if (code == cand) begin
          if (match_cnt != CONFIRM_C) begin
            match_nxt = match_cnt + 3'd1;
          end
        end else begin
          cand_nxt  = code;
          match_nxt = 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_SILENT;
      cand        <= NOTE_NONE;
      match_cnt   <= '0;
      notes       <= '0;
      silent      <= 1'b1;
      note_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      match_cnt   <= match_nxt;
      notes       <= notes_nxt;
      silent      <= silent_nxt;
      note_strobe <= strobe_nxt;
    end
  end

  assign {SI, FA, RE, SOL, MI, DO, LA} = notes;

endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: scoreboard bench for tone_detector. The stimulus process
// pushes each expected output change (value and clock cycle) before driving
// the rise that causes it; the monitor pops one entry on every observed change
// of {SI,FA,RE,SOL,MI,DO,LA,silent,note_strobe}.
module tb_tone_detector;

  localparam int unsigned TIMEOUT = 262143;
  localparam int unsigned P_LA    = 113636;
  localparam int unsigned P_DO    = 47778;
  localparam int unsigned P_MI    = 37922;
  localparam int unsigned P_SOL   = 127551;
  localparam int unsigned P_FA    = 35793;
  localparam int unsigned P_GAP   = 37000;   // between FA and MI windows
  localparam int unsigned P_DO_HI = 48524;   // last accepted DO period
  localparam int unsigned P_DO_X  = 48525;   // first rejected above DO

  localparam logic [6:0] OH_LA  = 7'b000_0001;
  localparam logic [6:0] OH_DO  = 7'b000_0010;
  localparam logic [6:0] OH_MI  = 7'b000_0100;
  localparam logic [6:0] OH_SOL = 7'b000_1000;
  localparam logic [6:0] OH_FA  = 7'b010_0000;

  typedef struct {
    logic [8:0]  vec;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tone_in = 1'b0;
  logic LA, DO, MI, SOL, RE, FA, SI, silent, note_strobe;

  logic [8:0]  obs;
  logic [8:0]  prev_obs = 9'b0000000_1_0;
  bit          mon_en = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  tone_detector #(
    .PER_W    (20),
    .TOL_SHIFT(6),
    .CONFIRM  (2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .LA         (LA),
    .DO         (DO),
    .MI         (MI),
    .SOL        (SOL),
    .RE         (RE),
    .FA         (FA),
    .SI         (SI),
    .silent     (silent),
    .note_strobe(note_strobe)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  assign obs = {SI, FA, RE, SOL, MI, DO, LA, silent, note_strobe};

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (obs != prev_obs)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %b at cycle %0d, required no change (was %b)",
                 obs, cyc, prev_obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.vec) begin
          errors++;
          $display("FAIL out_value: got %b, required %b (cycle %0d)", obs, e.vec, cyc);
        end
        checks++;
        if (cyc != e.at) begin
          errors++;
          $display("FAIL out_cycle: got cycle %0d, required cycle %0d (value %b)",
                   cyc, e.at, obs);
        end
      end
    end
    prev_obs = obs;
  end

  task automatic push(input logic [8:0] v, input int unsigned at);
    exp_t e;
    e.vec = v;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // Call at the negedge where the confirming rise is about to be driven:
  // pin -> rise is 3 clocks, then one more clock to the output registers.
  task automatic expect_lock(input logic [6:0] n);
    push({n, 1'b0, 1'b1}, cyc + 4);
    push({n, 1'b0, 1'b0}, cyc + 5);
  endtask

  task automatic expect_clear();
    push({7'b0, 1'b0, 1'b0}, cyc + 4);
  endtask

  // Drives a rise now, then one full period of p clocks (ends on a negedge).
  task automatic period(input int unsigned p);
    tone_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  initial begin
    #5 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 9'b0000000_1_0) begin
      errors++;
      $display("FAIL reset_state: got %b, required %b", obs, 9'b0000000_1_0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // Lock MI, then reset mid-stream while tone_in is high.
    period(P_MI);
    period(P_MI);
    expect_lock(OH_MI);
    period(P_MI);
    tone_in = 1'b1;
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2;
    push({7'b0, 1'b1, 1'b0}, cyc);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 9'b0000000_1_0) begin
      errors++;
      $display("FAIL async_reset: got %b, required %b", obs, 9'b0000000_1_0);
    end
    @(negedge clk);
    tone_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // LA from reset: locks only on the 3rd rise.
    period(P_LA);
    period(P_LA);
    expect_lock(OH_LA);
    period(P_LA);

    // LA -> FA: held through the first FA period.
    period(P_FA);
    period(P_FA);
    expect_lock(OH_FA);
    period(P_MI);

    // MI lock; single 37000 holds MI, two in a row clear.
    period(P_MI);
    expect_lock(OH_MI);
    period(P_GAP);
    period(P_MI);
    period(P_GAP);
    period(P_GAP);
    expect_clear();
    period(P_DO_HI);

    // DO upper window edge.
    period(P_DO_HI);
    expect_lock(OH_DO);
    period(P_DO_X);
    period(P_DO_X);
    expect_clear();
    period(P_SOL);

    // SOL, then input held high until timeout.
    period(P_SOL);
    expect_lock(OH_SOL);
    push({7'b0, 1'b1, 1'b0}, cyc + 3 + TIMEOUT);
    tone_in = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    tone_in = 1'b0;
    repeat (10) @(negedge clk);

    // From silence: first rise only arms; SOL, then input held low.
    period(P_SOL);
    period(P_SOL);
    expect_lock(OH_SOL);
    push({7'b0, 1'b1, 1'b0}, cyc + 3 + TIMEOUT);
    tone_in = 1'b1;
    repeat (P_SOL / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (TIMEOUT) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0 (next %b at cycle %0d)",
               exp_q.size(), exp_q[0].vec, exp_q[0].at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
